// File: rtl/ccff_chain_checker.sv
// Configuration flop chain checker: injects periodic marker bits at each
// chain head and compares the chain tails against the expected pattern.
module ccff_chain_checker #(
    parameter int NUM_CHAINS = 4,
    parameter int LEN_W      = 16,
    parameter int PER_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic                        prog_clk,
    input  logic                        pReset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [LEN_W-1:0]            cfg_chain_len,
    input  logic [PER_W-1:0]            cfg_period,
    input  logic [LEN_W-1:0]            cfg_check_cycles,
    input  logic [NUM_CHAINS-1:0]       chain_en,
    input  logic [NUM_CHAINS-1:0]       ccff_tail,
    output logic [NUM_CHAINS-1:0]       ccff_head,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [NUM_CHAINS-1:0]       err_flag,
    output logic [NUM_CHAINS*ERR_W-1:0] err_cnt,
    output logic [LEN_W-1:0]            first_err_cycle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      chk_q;
    logic [LEN_W-1:0]      cyc_cnt;
    logic [PER_W-1:0]      per_q;
    logic [PER_W-1:0]      inj_cnt;
    logic [PER_W-1:0]      inj_nxt;
    logic [PER_W-1:0]      inj_inc;
    logic [PER_W-1:0]      phase_cnt;
    logic [PER_W-1:0]      phase_inc;
    logic [NUM_CHAINS-1:0] en_q;
    logic [NUM_CHAINS-1:0] en_nxt;
    logic [NUM_CHAINS-1:0] mis;
    logic [NUM_CHAINS-1:0] flag_nxt;
    logic                  accept;
    logic                  run_abort;
    logic                  fill_last;
    logic                  check_last;
    logic                  exp_bit;
    logic                  run_nxt;

    assign accept     = (state == S_IDLE) && start && !abort;
    assign run_abort  = abort && ((state == S_FILL) || (state == S_CHECK));
    assign fill_last  = cyc_cnt == len_q - LEN_W'(1);
    assign check_last = cyc_cnt == chk_q - LEN_W'(1);
    assign en_nxt     = accept ? chain_en : en_q;

    assign inj_inc   = (inj_cnt == per_q - PER_W'(1)) ? '0 : inj_cnt + PER_W'(1);
    assign phase_inc = (phase_cnt == per_q - PER_W'(1)) ? '0 : phase_cnt + PER_W'(1);

    // Expected tail value comes from the CHECK-local phase, not a delay line
    assign exp_bit  = phase_cnt == '0;
    assign mis      = ((state == S_CHECK) && !abort)
                    ? (en_q & (ccff_tail ^ {NUM_CHAINS{exp_bit}})) : '0;
    assign flag_nxt = err_flag | mis;

    always_comb begin
        state_nxt = state;
        inj_nxt   = inj_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    inj_nxt = '0;
                    if (cfg_chain_len != '0)
                        state_nxt = S_FILL;
                    else if (cfg_check_cycles != '0)
                        state_nxt = S_CHECK;
                    else
                        state_nxt = S_DONE;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    inj_nxt = inj_inc;
                    if (fill_last)
                        state_nxt = (chk_q == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    inj_nxt = inj_inc;
                    if (check_last)
                        state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign run_nxt = (state_nxt == S_FILL) || (state_nxt == S_CHECK);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state           <= S_IDLE;
            len_q           <= '0;
            chk_q           <= '0;
            per_q           <= '0;
            en_q            <= '0;
            cyc_cnt         <= '0;
            inj_cnt         <= '0;
            phase_cnt       <= '0;
            ccff_head       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_flag        <= '0;
            err_cnt         <= '0;
            first_err_cycle <= '1;
        end else begin
            state     <= state_nxt;
            inj_cnt   <= inj_nxt;
            ccff_head <= (run_nxt && (inj_nxt == '0)) ? en_nxt : '0;
            busy      <= run_nxt;
            done      <= state_nxt == S_DONE;
            if (accept) begin
                len_q           <= cfg_chain_len;
                chk_q           <= cfg_check_cycles;
                per_q           <= (cfg_period == '0) ? PER_W'(1) : cfg_period;
                en_q            <= chain_en;
                cyc_cnt         <= '0;
                phase_cnt       <= '0;
                err_flag        <= '0;
                err_cnt         <= '0;
                first_err_cycle <= '1;
                pass            <= state_nxt == S_DONE;
            end else begin
                if ((state == S_FILL) && fill_last) begin
                    cyc_cnt   <= '0;
                    phase_cnt <= '0;
                end else if ((state == S_FILL) || (state == S_CHECK)) begin
                    cyc_cnt <= cyc_cnt + LEN_W'(1);
                end
                if (state == S_CHECK)
                    phase_cnt <= phase_inc;
                err_flag <= flag_nxt;
                for (int i = 0; i < NUM_CHAINS; i++) begin
                    if (mis[i] && (err_cnt[i*ERR_W +: ERR_W] != {ERR_W{1'b1}}))
                        err_cnt[i*ERR_W +: ERR_W] <= err_cnt[i*ERR_W +: ERR_W] + ERR_W'(1);
                end
                if ((|mis) && !(|err_flag))
                    first_err_cycle <= cyc_cnt;
                if (run_abort)
                    pass <= 1'b0;
                else if (state_nxt == S_DONE)
                    pass <= ~|flag_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_checker.sv
// Bench for ccff_chain_checker: behavioural flop chains with injected faults,
// a vector table of runs, and hand sequences for abort and reset.
module tb_ccff_chain_checker;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int PW = 8;

    typedef struct {
        int          len;
        int          per;
        int          chk;
        logic [3:0]  en;
        int          m;
        int          fch;
        int          fk;
        logic        pass;
        logic [3:0]  flag;
        logic [31:0] cnt;
        logic [15:0] cnt4;
        logic [15:0] first;
        int          lat;
    } vec_t;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          abort;
    logic [LW-1:0] cfg_chain_len;
    logic [PW-1:0] cfg_period;
    logic [LW-1:0] cfg_check_cycles;
    logic [N-1:0]  chain_en;

    logic [N-1:0]   tail_a, head_a, flag_a;
    logic [N-1:0]   tail_b, head_b, flag_b;
    logic           busy_a, done_a, pass_a;
    logic           busy_b, done_b, pass_b;
    logic [N*8-1:0] cnt_a;
    logic [N*4-1:0] cnt_b;
    logic [LW-1:0]  first_a, first_b;

    int          cur_m = 0;
    int          cur_fch = -1;
    int          cur_fk = 0;
    int unsigned fault_at = 0;
    int unsigned cyc_ctr = 0;
    logic [63:0] sr_a [N];
    logic [63:0] sr_b [N];

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[11];
    vec_t sbq[$];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_checker dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .start           (start),
        .abort           (abort),
        .cfg_chain_len   (cfg_chain_len),
        .cfg_period      (cfg_period),
        .cfg_check_cycles(cfg_check_cycles),
        .chain_en        (chain_en),
        .ccff_tail       (tail_a),
        .ccff_head       (head_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_flag        (flag_a),
        .err_cnt         (cnt_a),
        .first_err_cycle (first_a)
    );

    ccff_chain_checker #(.ERR_W(4)) dut4 (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .start           (start),
        .abort           (abort),
        .cfg_chain_len   (cfg_chain_len),
        .cfg_period      (cfg_period),
        .cfg_check_cycles(cfg_check_cycles),
        .chain_en        (chain_en),
        .ccff_tail       (tail_b),
        .ccff_head       (head_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_flag        (flag_b),
        .err_cnt         (cnt_b),
        .first_err_cycle (first_b)
    );

    // Chain model: tail is the head delayed by the chain's flop count
    always @(posedge prog_clk) begin
        cyc_ctr <= cyc_ctr + 1;
        for (int i = 0; i < N; i++) begin
            sr_a[i] <= {sr_a[i][62:0], head_a[i]};
            sr_b[i] <= {sr_b[i][62:0], head_b[i]};
        end
    end

    function automatic logic tap(input logic [63:0] sr, input logic hd,
                                 input int m);
        if (m == 0)
            return hd;
        return sr[m-1];
    endfunction

    function automatic logic fault(input logic v, input int i);
        if (cur_fch != i)
            return v;
        if (cur_fk == 1)
            return 1'b0;
        if (cur_fk == 2)
            return 1'b1;
        if ((cur_fk == 4) && (cyc_ctr == fault_at))
            return 1'b0;
        return v;
    endfunction

    always_comb begin
        tail_a = '0;
        tail_b = '0;
        for (int i = 0; i < N; i++) begin
            tail_a[i] = fault(tap(sr_a[i], head_a[i],
                        cur_m + (((cur_fk == 3) && (cur_fch == i)) ? 1 : 0)), i);
            tail_b[i] = fault(tap(sr_b[i], head_b[i],
                        cur_m + (((cur_fk == 3) && (cur_fch == i)) ? 1 : 0)), i);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input int per, input int chk_n,
                                input logic [3:0] en, input int m,
                                input int fch, input int fk,
                                input logic p, input logic [3:0] fl,
                                input logic [31:0] c, input logic [15:0] c4,
                                input logic [15:0] f, input int lat);
        vec_t v;
        v.len = len; v.per = per; v.chk = chk_n; v.en = en;
        v.m = m; v.fch = fch; v.fk = fk; v.pass = p; v.flag = fl;
        v.cnt = c; v.cnt4 = c4; v.first = f; v.lat = lat;
        return v;
    endfunction

    task automatic setup(input vec_t v);
        cur_m            = v.m;
        cur_fch          = v.fch;
        cur_fk           = v.fk;
        cfg_chain_len    = LW'(v.len);
        cfg_period       = PW'(v.per);
        cfg_check_cycles = LW'(v.chk);
        chain_en         = v.en;
    endtask

    task automatic wait_check(input int lat0);
        vec_t e;
        int   lat;
        lat = lat0;
        while (!done_a && lat < 300) begin
            @(posedge prog_clk);
            #1;
            lat++;
        end
        e = sbq.pop_front();
        chk("done_seen", done_a, 1);
        chk("done4_seen", done_b, 1);
        chk("latency", lat, e.lat);
        chk("pass", pass_a, e.pass);
        chk("pass4", pass_b, e.pass);
        chk("err_flag", flag_a, e.flag);
        chk("err_cnt", cnt_a, e.cnt);
        chk("err_cnt4", cnt_b, e.cnt4);
        chk("first_err", first_a, e.first);
        @(posedge prog_clk);
        #1;
        chk("done_pulse", done_a, 0);
        chk("busy_idle", busy_a, 0);
        chk("pass_hold", pass_a, e.pass);
        chk("head_idle", head_a, 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge prog_clk);
        setup(v);
        start    = 1'b1;
        fault_at = cyc_ctr + v.len + v.chk;
        sbq.push_back(v);
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        wait_check(1);
        repeat (20) @(posedge prog_clk);
    endtask

    task automatic abort_run(input int kab, input vec_t v,
                             input logic [31:0] ecnt, input logic [3:0] eflag,
                             input logic [15:0] efirst);
        int ndone;
        @(negedge prog_clk);
        setup(v);
        start    = 1'b1;
        fault_at = 0;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        repeat (v.len + kab) @(posedge prog_clk);
        #1;
        chk("abort_busy_pre", busy_a, 1);
        abort = 1'b1;
        @(posedge prog_clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_head", head_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_flag", flag_a, eflag);
        chk("abort_cnt", cnt_a, ecnt);
        chk("abort_first", first_a, efirst);
        ndone = 0;
        repeat (50) begin
            @(posedge prog_clk);
            #1;
            if (done_a)
                ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_cnt_hold", cnt_a, ecnt);
        chk("abort_busy_hold", busy_a, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pReset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_chain_len = '0;
        cfg_period = '0;
        cfg_check_cycles = '0;
        chain_en = '0;

        tbl[0]  = mk(10, 3, 30, 4'hF, 10, -1, 0, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 41);
        tbl[1]  = mk(10, 4, 32, 4'hF, 10, 2, 3, 0, 4'h4, 32'h0010_0000, 16'h0F00, 16'h0, 43);
        tbl[2]  = mk(10, 3, 30, 4'hD, 10, 1, 1, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 41);
        tbl[3]  = mk(10, 1, 40, 4'hF, 10, 0, 2, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 51);
        tbl[4]  = mk(10, 2, 40, 4'hF, 10, 0, 2, 0, 4'h1, 32'h14, 16'h000F, 16'h1, 51);
        tbl[5]  = mk(0, 2, 6, 4'hF, 0, -1, 0, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 7);
        tbl[6]  = mk(5, 0, 8, 4'hF, 5, 3, 1, 0, 4'h8, 32'h0800_0000, 16'h8000, 16'h0, 14);
        tbl[7]  = mk(4, 3, 0, 4'hF, 4, 0, 2, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 5);
        tbl[8]  = mk(0, 1, 0, 4'hF, 0, -1, 0, 1, 4'h0, 32'h0, 16'h0, 16'hFFFF, 1);
        tbl[9]  = mk(3, 5, 6, 4'hF, 3, 1, 4, 0, 4'h2, 32'h100, 16'h0010, 16'h5, 10);
        tbl[10] = mk(7, 3, 12, 4'h7, 7, 2, 1, 0, 4'h4, 32'h0004_0000, 16'h0400, 16'h0, 20);

        repeat (20) @(posedge prog_clk);
        @(negedge prog_clk);
        pReset = 1'b0;
        @(posedge prog_clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_head", head_a, 0);
        chk("rst_flag", flag_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_first", first_a, 16'hFFFF);
        chk("rst_cnt4", cnt_b, 0);

        for (int i = 0; i < 11; i++)
            run_vec(tbl[i]);

        abort_run(5, tbl[0], 32'h0, 4'h0, 16'hFFFF);
        repeat (20) @(posedge prog_clk);
        abort_run(3, tbl[1], 32'h0002_0000, 4'h4, 16'h0);

        // Reset in IDLE clears held error state
        @(negedge prog_clk);
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        chk("idle_rst_cnt", cnt_a, 0);
        chk("idle_rst_flag", flag_a, 0);
        chk("idle_rst_first", first_a, 16'hFFFF);
        @(negedge prog_clk);
        pReset = 1'b0;
        repeat (20) @(posedge prog_clk);

        // Reset mid-FILL with start held high
        @(negedge prog_clk);
        setup(tbl[0]);
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        repeat (3) @(posedge prog_clk);
        #1;
        chk("fill_busy", busy_a, 1);
        @(negedge prog_clk);
        pReset = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_pass", pass_a, 0);
        chk("mid_rst_head", head_a, 0);
        chk("mid_rst_flag", flag_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        chk("mid_rst_first", first_a, 16'hFFFF);
        @(negedge prog_clk);
        pReset = 1'b0;
        fault_at = 0;
        sbq.push_back(tbl[0]);
        @(posedge prog_clk);
        #1;
        chk("restart_busy", busy_a, 1);
        chk("restart_head", head_a, 4'hF);
        start = 1'b0;
        wait_check(1);
        repeat (20) @(posedge prog_clk);

        // Abort wins over start in IDLE
        @(negedge prog_clk);
        setup(tbl[0]);
        start = 1'b1;
        abort = 1'b1;
        @(posedge prog_clk);
        #1;
        chk("idle_abort_busy", busy_a, 0);
        chk("idle_abort_head", head_a, 0);
        @(negedge prog_clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        chk("idle_abort_stay", busy_a, 0);

        run_vec(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
